// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage
//   Front end of the MIPS pipeline. It holds the PC and selects the next PC
//   (sequential, branch or jump). It presents the PC to a combinational
//   instruction memory and registers the returned word into IF/ID.
//   Also handles stall, redirect/flush, sticky fetch-fault detection and
//   a count of retired fetches.
//
// Ports
//   Clk               in   system clock, rising-edge
//   Reset             in   synchronous active-low reset
//   Stall             in   hold PC and IF/ID
//   BranchTaken       in   taken branch from ID
//   BranchTarget      in   [31:0] branch byte address
//   JumpTaken         in   j/jal/jr redirect from ID (wins over branch)
//   JumpTarget        in   [31:0] jump byte address
//   FetchAddress      out  [31:0] byte address to imem (= PC register)
//   FetchInstruction  in   [31:0] imem word for FetchAddress
//   IF_ID_Instruction out  [31:0] registered instruction
//   IF_ID_PCPlus4     out  [31:0] registered PC+4 of that instruction
//   IF_ID_Valid       out  IF/ID holds a real instruction
//   FetchFault        out  sticky illegal-PC flag
//   FetchCount        out  [31:0] valid instructions loaded into IF/ID
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 128,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] FetchAddress,
    input  logic [31:0] FetchInstruction,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        FetchFault,
    output logic [31:0] FetchCount
);

    // One past the last legal byte address; 33 bits so a full 2^32 space
    // still compares correctly.
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic        illegal_pc;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4   = pc_q + 32'd4;
    assign illegal_pc = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= IMEM_BYTES);

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        count_d    = count_q;

        if (JumpTaken || BranchTaken) begin
            // Redirect beats stall and fault; the word fetched now is dropped.
            pc_d    = JumpTaken ? JumpTarget : BranchTarget;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (fault_q) begin
            // Halted until reset: keep bubbling.
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (Stall) begin
            // Everything holds (defaults).
        end else if (illegal_pc) begin
            fault_d = 1'b1;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else begin
            pc_d       = pc_plus4;
            instr_d    = FetchInstruction;
            pc_plus4_d = pc_plus4;
            valid_d    = 1'b1;
            count_d    = count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_WORD;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    assign FetchAddress      = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pc_plus4_q;
    assign IF_ID_Valid       = valid_q;
    assign FetchFault        = fault_q;
    assign FetchCount        = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage. A behavioural 128-word
// instruction memory returns word index * 3 for any fetch address.
module tb_instruction_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        JumpTaken;
    logic [31:0] JumpTarget;
    logic [31:0] FetchAddress;
    logic [31:0] FetchInstruction;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        FetchFault;
    logic [31:0] FetchCount;

    int checks   = 0;
    int failures = 0;

    instruction_fetch_stage dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .Stall             (Stall),
        .BranchTaken       (BranchTaken),
        .BranchTarget      (BranchTarget),
        .JumpTaken         (JumpTaken),
        .JumpTarget        (JumpTarget),
        .FetchAddress      (FetchAddress),
        .FetchInstruction  (FetchInstruction),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .FetchFault        (FetchFault),
        .FetchCount        (FetchCount)
    );

    always #5 Clk = ~Clk;

    // memory[i] = i*3, indexed by address bits [8:2]
    always_comb FetchInstruction = 32'(FetchAddress[8:2]) * 32'd3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pc"},    FetchAddress,        32'h0);
        check({tag, ".instr"}, IF_ID_Instruction,   32'h0);
        check({tag, ".pc4"},   IF_ID_PCPlus4,       32'h0);
        check({tag, ".valid"}, 32'(IF_ID_Valid),    32'd0);
        check({tag, ".fault"}, 32'(FetchFault),     32'd0);
        check({tag, ".count"}, FetchCount,          32'd0);
    endtask

    initial begin
        Reset = 1'b0; Stall = 1'b0;
        BranchTaken = 1'b0; BranchTarget = 32'h0;
        JumpTaken = 1'b0; JumpTarget = 32'h0;
        #2;
        step(); step();
        check_reset_state("rst");

        // 1. sequential fetch
        Reset = 1'b1;
        step();
        check("seq1.instr", IF_ID_Instruction, 32'd0);
        check("seq1.pc4",   IF_ID_PCPlus4,     32'd4);
        check("seq1.valid", 32'(IF_ID_Valid),  32'd1);
        step();
        check("seq2.instr", IF_ID_Instruction, 32'd3);
        check("seq2.pc4",   IF_ID_PCPlus4,     32'd8);
        step(); step();
        check("seq4.pc",    FetchAddress,      32'h10);
        check("seq4.instr", IF_ID_Instruction, 32'd9);
        check("seq4.count", FetchCount,        32'd4);

        // 2. stall for 3 cycles at PC=0x10
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.pc",    FetchAddress,      32'h10);
            check("stall.instr", IF_ID_Instruction, 32'd9);
            check("stall.pc4",   IF_ID_PCPlus4,     32'h10);
            check("stall.count", FetchCount,        32'd4);
        end
        Stall = 1'b0;
        step();
        check("unstall.instr", IF_ID_Instruction, 32'd12);
        check("unstall.count", FetchCount,        32'd5);
        check("unstall.pc",    FetchAddress,      32'h14);

        // 3. branch with simultaneous stall at PC=0x20
        step(); step(); step();
        check("pre_br.pc", FetchAddress, 32'h20);
        BranchTaken = 1'b1; BranchTarget = 32'h40; Stall = 1'b1;
        step();
        BranchTaken = 1'b0; Stall = 1'b0;
        check("br.pc",    FetchAddress,      32'h40);
        check("br.valid", 32'(IF_ID_Valid),  32'd0);
        check("br.instr", IF_ID_Instruction, 32'd0);
        check("br.pc4",   IF_ID_PCPlus4,     32'h20);
        check("br.count", FetchCount,        32'd8);
        step();
        check("br_tgt.instr", IF_ID_Instruction, 32'd48);
        check("br_tgt.pc4",   IF_ID_PCPlus4,     32'h44);
        check("br_tgt.valid", 32'(IF_ID_Valid),  32'd1);

        // 4. jump wins over branch
        JumpTaken = 1'b1; JumpTarget = 32'h08;
        BranchTaken = 1'b1; BranchTarget = 32'h60;
        step();
        JumpTaken = 1'b0; BranchTaken = 1'b0;
        check("jmp.pc",    FetchAddress,     32'h08);
        check("jmp.valid", 32'(IF_ID_Valid), 32'd0);
        step();
        check("jmp_tgt.instr", IF_ID_Instruction, 32'd6);
        check("jmp_tgt.pc4",   IF_ID_PCPlus4,     32'h0C);
        check("jmp_tgt.count", FetchCount,        32'd10);

        // 5. misaligned jump target faults
        JumpTaken = 1'b1; JumpTarget = 32'h202;
        step();
        JumpTaken = 1'b0;
        check("mis.pc",    FetchAddress,    32'h202);
        check("mis.fault", 32'(FetchFault), 32'd0);
        step();
        check("mis_f.fault", 32'(FetchFault),  32'd1);
        check("mis_f.valid", 32'(IF_ID_Valid), 32'd0);
        check("mis_f.pc",    FetchAddress,     32'h202);
        check("mis_f.count", FetchCount,       32'd10);
        JumpTaken = 1'b1; JumpTarget = 32'h0;
        step();
        JumpTaken = 1'b0;
        check("flt_jmp.pc",    FetchAddress,    32'h0);
        check("flt_jmp.fault", 32'(FetchFault), 32'd1);
        step();
        check("flt_hold.pc",    FetchAddress,      32'h0);
        check("flt_hold.valid", 32'(IF_ID_Valid),  32'd0);
        check("flt_hold.instr", IF_ID_Instruction, 32'd0);
        check("flt_hold.fault", 32'(FetchFault),   32'd1);
        check("flt_hold.count", FetchCount,        32'd10);

        // 6. run off the end of memory
        Reset = 1'b0;
        step();
        check_reset_state("rst2");
        Reset = 1'b1;
        for (int i = 0; i < 127; i++) step();
        check("end.pc",    FetchAddress, 32'h1FC);
        check("end.count", FetchCount,   32'd127);
        step();
        check("last.instr", IF_ID_Instruction, 32'd381);
        check("last.valid", 32'(IF_ID_Valid),  32'd1);
        check("last.pc4",   IF_ID_PCPlus4,     32'h200);
        check("last.pc",    FetchAddress,      32'h200);
        check("last.fault", 32'(FetchFault),   32'd0);
        step();
        check("oob.fault", 32'(FetchFault),  32'd1);
        check("oob.valid", 32'(IF_ID_Valid), 32'd0);
        check("oob.pc",    FetchAddress,     32'h200);
        check("oob.count", FetchCount,       32'd128);
        check("oob.pc4",   IF_ID_PCPlus4,    32'h200);

        // reset while stalled and redirecting
        Stall = 1'b1;
        step();
        Reset = 1'b0;
        JumpTaken = 1'b1; JumpTarget = 32'h40;
        step();
        check_reset_state("rst3");
        Stall = 1'b0; JumpTaken = 1'b0; Reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front end of the MIPS pipeline, directly upstream of the instruction memory and feeding the decode stage.
- Holds the program counter and computes the next PC: sequential, branch or jump.
- Drives the fetch address into the 128-word combinational instruction memory and registers the returned word into the IF/ID pipeline register.
- Handles stall, redirect/flush, fetch-fault detection and a retired-fetch counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_WORDS, 128, instruction memory depth in words; legal byte addresses are 0 .. IMEM_WORDS*4-4.
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on bubble or flush.

Ports:
Clk  in  1  system clock; all state updates on rising edge.
Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clk.
Stall  in  1  hazard unit holds PC and IF/ID contents.
BranchTaken  in  1  resolved taken branch from ID.
BranchTarget  in  32  branch byte address.
JumpTaken  in  1  j/jal/jr redirect from ID.
JumpTarget  in  32  jump byte address.
FetchAddress  out  32  byte address to instruction memory; combinationally equal to the PC register.
FetchInstruction  in  32  word returned combinationally by instruction memory for FetchAddress.
IF_ID_Instruction  out  32  registered instruction to decode.
IF_ID_PCPlus4  out  32  registered PC+4 of that instruction.
IF_ID_Valid  out  1  IF/ID holds a real instruction.
FetchFault  out  1  sticky: an illegal PC was presented for fetch.
FetchCount  out  32  number of instructions loaded into IF/ID with valid=1.

Behaviour:
- Reset (Reset==0 at edge):
  - PC=RESET_PC.
  - IF_ID_Instruction=NOP_WORD, IF_ID_PCPlus4=0, IF_ID_Valid=0.
  - FetchFault=0, FetchCount=0.
  - Reset overrides every other input, including mid-stall and mid-redirect.
- PC+4 is a 32-bit add; it wraps modulo 2^32 with no flag.
- Illegal PC: PC[1:0]!=0 OR PC >= IMEM_WORDS*4. This is evaluated combinationally on the current PC.
- Per edge, with Reset==1, the first matching case applies:
  1. Redirect (JumpTaken | BranchTaken):
     - PC <= JumpTarget if JumpTaken, else BranchTarget. Jump wins when both are asserted.
     - IF/ID flushed: Instruction=NOP_WORD, Valid=0, PCPlus4 unchanged.
     - Redirect overrides Stall. There is no delay slot; the word fetched this cycle is discarded.
  2. FetchFault already set: PC holds, and IF/ID loads a bubble (NOP_WORD, Valid=0). The block is halted until reset.
  3. Stall: PC, IF/ID and FetchCount all hold.
  4. Illegal PC:
     - FetchFault <= 1 and PC holds.
     - IF/ID loads a bubble; FetchCount unchanged.
  5. Normal:
     - PC <= PC+4.
     - IF_ID_Instruction <= FetchInstruction, IF_ID_PCPlus4 <= PC+4, IF_ID_Valid <= 1.
     - FetchCount <= FetchCount+1, wrapping at 2^32.
- A redirect still applies while FetchFault is set; the fault flag stays set until reset.
- Latency: an instruction appears on IF_ID_* one edge after its PC is presented. A redirect target is fetched in the cycle after the redirect edge.
- FetchAddress is never gated; the memory indexes bits [8:2] regardless of fault.
- Outputs are purely registered except FetchAddress.

Test Plan:
1. Reset low for 2 edges, then high with the memory pattern memory[i]=i*3:
   - Edge 1: IF_ID_Instruction=0, PCPlus4=4, Valid=1.
   - Edge 2: Instruction=3, PCPlus4=8.
   - After 5 edges: FetchCount=5, FetchAddress=0x14.
2. At PC=0x10, assert Stall for 3 cycles: PC stays 0x10, IF/ID holds word 9 (PCPlus4=0x10), FetchCount frozen. On release the next edge loads word 12.
3. At PC=0x20, BranchTaken=1 with BranchTarget=0x40 and Stall=1 simultaneously:
   - Next edge: PC=0x40, Valid=0, Instruction=0.
   - Following edge: Instruction=48, PCPlus4=0x44.
4. JumpTaken=1 (JumpTarget=0x08) and BranchTaken=1 (BranchTarget=0x60) together: PC=0x08, then IF/ID Instruction=6.
5. JumpTarget=0x202 (misaligned):
   - Next edge: PC=0x202.
   - Following edge: FetchFault=1, Valid=0, PC stays 0x202.
   - Later JumpTarget=0x0 still moves PC, but IF/ID stays bubbled with FetchFault=1 until Reset low.
6. Run PC up to 0x1FC:
   - Word 381 is loaded with Valid=1.
   - At PC=0x200: FetchFault=1, FetchCount=128, PC holds 0x200.
   - Drop Reset mid-stall: all outputs return to their reset values on the next edge.
